// File: rtl/irq_sched_pkg.sv
// Shared types and sizes for the 27-source interrupt scheduler.
// Contents: bus/channel geometry, bus and FSM state enums, offered-vector payload.
package irq_sched_pkg;

    localparam int unsigned NCH   = 9;   // channels per bus
    localparam int unsigned NBUS  = 3;   // buses, A highest priority
    localparam int unsigned CH_W  = 4;   // channel index width
    localparam int unsigned BUS_W = 2;   // bus index width

    typedef enum logic [BUS_W-1:0] {
        BUS_A = 2'd0,
        BUS_B = 2'd1,
        BUS_C = 2'd2
    } bus_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        OFFER   = 2'd2,
        SERVICE = 2'd3
    } state_e;

    // One bit per (bus, channel); index [0] is bus A.
    typedef logic [NBUS-1:0][NCH-1:0] chmap_t;

endpackage

// File: rtl/irq_prio_resolve.sv
// Fixed-priority winner selection across the three buses (combinational).
// Ports:
//   i_elig     eligible sources, [bus][channel]
//   o_any_c    at least one source eligible
//   o_bus_c    winning bus (A beats B beats C)
//   o_chan_c   winning channel (lowest index within the bus)
module irq_prio_resolve
    import irq_sched_pkg::*;
(
    input  chmap_t          i_elig,
    output logic            o_any_c,
    output bus_e            o_bus_c,
    output logic [CH_W-1:0] o_chan_c
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_any_c  = 1'b0;
        o_bus_c  = BUS_A;
        o_chan_c = '0;
        for (int b = NBUS - 1; b >= 0; b--) begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (i_elig[b][c]) begin
                    o_any_c  = 1'b1;
                    o_bus_c  = bus_e'(BUS_W'(b));
                    o_chan_c = CH_W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/irq_sched_27ch.sv
// Interrupt scheduler: captures request edges from three 9-channel buses,
// arbitrates by fixed priority and offers one vector at a time to the CPU,
// holding off further offers until end-of-interrupt.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_a/req_b/req_c      raw request levels per bus
//   chan_en                per-channel enable shared by all buses
//   irq_valid/irq_ready    vector offer handshake
//   irq_bus/irq_chan       offered vector
//   eoi                    end-of-interrupt pulse
//   busy_any               per-bus OR of enabled pending bits
//   lost, lost_clr         sticky per-bus overrun flags and their clear
module irq_sched_27ch
    import irq_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req_a,
    input  logic [NCH-1:0]   req_b,
    input  logic [NCH-1:0]   req_c,
    input  logic [NCH-1:0]   chan_en,
    output logic             irq_valid,
    input  logic             irq_ready,
    output logic [BUS_W-1:0] irq_bus,
    output logic [CH_W-1:0]  irq_chan,
    input  logic             eoi,
    output logic [NBUS-1:0]  busy_any,
    output logic [NBUS-1:0]  lost,
    input  logic             lost_clr
);

    chmap_t          w_req;
    chmap_t          w_edge;
    chmap_t          w_elig;
    chmap_t          w_grant_mask;
    chmap_t          w_pend_nxt;
    chmap_t          r_req_prev;
    chmap_t          r_pend;
    logic            r_hist_vld;

    state_e          r_state;
    state_e          w_state_nxt;
    logic            w_load_vec;
    logic            w_valid_nxt;
    logic            w_grant;

    logic            r_valid;
    bus_e            r_bus;
    logic [CH_W-1:0] r_chan;
    logic [NBUS-1:0] r_busy;
    logic [NBUS-1:0] r_lost;
    logic [NBUS-1:0] w_busy_nxt;
    logic [NBUS-1:0] w_lost_set;

    logic            w_any;
    bus_e            w_win_bus;
    logic [CH_W-1:0] w_win_chan;

    assign w_req = {req_c, req_b, req_a};

    // The first cycle after reset only samples history, so levels already high
    // when reset releases are not mistaken for fresh edges.
    assign w_edge = w_req & ~r_req_prev & {(NBUS * NCH){r_hist_vld}};

    // Eligibility, grant clear, pending update, overrun detection.
    always_comb begin
        w_elig       = '0;
        w_grant_mask = '0;
        w_busy_nxt   = '0;
        w_lost_set   = '0;
        for (int b = 0; b < NBUS; b++) begin
            w_elig[b]     = r_pend[b] & chan_en;
            w_busy_nxt[b] = |w_elig[b];
            for (int c = 0; c < NCH; c++) begin
                w_grant_mask[b][c] = w_grant
                                   && (r_bus == bus_e'(BUS_W'(b)))
                                   && (r_chan == CH_W'(c));
            end
            // An edge coinciding with its own grant re-arms the bit, not an overrun.
            w_lost_set[b] = |(w_edge[b] & r_pend[b] & ~w_grant_mask[b]);
        end
        w_pend_nxt = (r_pend & ~w_grant_mask) | w_edge;
    end

    irq_prio_resolve u_resolve (
        .i_elig   (w_elig),
        .o_any_c  (w_any),
        .o_bus_c  (w_win_bus),
        .o_chan_c (w_win_chan)
    );

    // Next-state and registered-output control.
    always_comb begin
        w_state_nxt = r_state;
        w_load_vec  = 1'b0;
        w_valid_nxt = r_valid;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                // Re-resolve here so a dropped enable cancels the offer.
                if (w_any) begin
                    w_state_nxt = OFFER;
                    w_load_vec  = 1'b1;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OFFER: begin
                if (irq_ready) begin
                    w_grant     = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_prev <= '0;
            r_hist_vld <= 1'b0;
            r_pend     <= '0;
            r_busy     <= '0;
            r_lost     <= '0;
            r_valid    <= 1'b0;
            r_bus      <= BUS_A;
            r_chan     <= '0;
        end else begin
            r_req_prev <= w_req;
            r_hist_vld <= 1'b1;
            r_pend     <= w_pend_nxt;
            r_busy     <= w_busy_nxt;
            r_lost     <= lost_clr ? '0 : (r_lost | w_lost_set);
            r_valid    <= w_valid_nxt;
            if (w_load_vec) begin
                r_bus  <= w_win_bus;
                r_chan <= w_win_chan;
            end
        end
    end

    assign irq_valid = r_valid;
    assign irq_bus   = r_bus;
    assign irq_chan  = r_chan;
    assign busy_any  = r_busy;
    assign lost      = r_lost;

endmodule

// File: tb/tb_irq_sched_27ch.sv
// Scoreboard bench for irq_sched_27ch: directed scenarios push expected vectors,
// an independent monitor pops and compares on each accepted offer.
module tb_irq_sched_27ch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] req_a, req_b, req_c, chan_en;
    logic       irq_valid, irq_ready, eoi, lost_clr;
    logic [1:0] irq_bus;
    logic [3:0] irq_chan;
    logic [2:0] busy_any, lost;

    typedef struct {
        int    bus;
        int    chan;
        string nm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    irq_sched_27ch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .chan_en   (chan_en),
        .irq_valid (irq_valid),
        .irq_ready (irq_ready),
        .irq_bus   (irq_bus),
        .irq_chan  (irq_chan),
        .eoi       (eoi),
        .busy_any  (busy_any),
        .lost      (lost),
        .lost_clr  (lost_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int b, input int c, input string nm);
        exp_t e;
        e.bus  = b;
        e.chan = c;
        e.nm   = nm;
        return e;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!irq_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_offer_seen"}, 32'(irq_valid), 32'd1);
    endtask

    task automatic ack();
        irq_ready = 1'b1;
        @(negedge clk);
        irq_ready = 1'b0;
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
    endtask

    // Monitor: every accepted offer must match the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && irq_valid && irq_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_offer: got bus %0d chan %0d with empty queue",
                             irq_bus, irq_chan);
                end else begin
                    e = q.pop_front();
                    chk({e.nm, "_bus"},  32'(irq_bus),  32'(e.bus));
                    chk({e.nm, "_chan"}, 32'(irq_chan), 32'(e.chan));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        rst_n = 1'b0; req_a = '0; req_b = '0; req_c = '0; chan_en = '1;
        irq_ready = 1'b0; eoi = 1'b0; lost_clr = 1'b0;
        cyc(3);
        chk("rst_valid", 32'(irq_valid), 32'd0);
        chk("rst_bus",   32'(irq_bus),   32'd0);
        chk("rst_chan",  32'(irq_chan),  32'd0);
        chk("rst_busy",  32'(busy_any),  32'd0);
        chk("rst_lost",  32'(lost),      32'd0);
        rst_n = 1'b1;
        cyc(2);

        // 1: single source B/4, three-cycle latency, ack then service
        req_b[4] = 1'b1;
        q.push_back(mk(1, 4, "t1"));
        cyc(1); chk("t1_lat1", 32'(irq_valid), 32'd0);
        cyc(1); chk("t1_lat2", 32'(irq_valid), 32'd0);
        cyc(1); chk("t1_lat3", 32'(irq_valid), 32'd1);
        chk("t1_busy", 32'(busy_any), 32'd2);
        ack();
        chk("t1_valid_drop", 32'(irq_valid), 32'd0);
        chk("t1_state_service", 32'(dut.r_state), 32'd3);
        cyc(1); chk("t1_pend_clr", 32'(busy_any), 32'd0);
        eoi_pulse();
        cyc(3); chk("t1_quiet", 32'(irq_valid), 32'd0);
        req_b = '0;

        // 2: contention A/2, A/7, C/0; minimum gap after eoi
        req_c[0] = 1'b1; req_a[7] = 1'b1; req_a[2] = 1'b1;
        q.push_back(mk(0, 2, "t2a"));
        q.push_back(mk(0, 7, "t2b"));
        q.push_back(mk(2, 0, "t2c"));
        wait_valid("t2a");
        ack(); cyc(1); eoi_pulse();
        chk("t2_gap1", 32'(irq_valid), 32'd0);
        cyc(1); chk("t2_gap2", 32'(irq_valid), 32'd0);
        cyc(1); chk("t2_gap3", 32'(irq_valid), 32'd1);
        ack(); cyc(1); eoi_pulse();
        wait_valid("t2c");
        ack(); cyc(1); eoi_pulse();
        req_a = '0; req_c = '0;
        cyc(2);

        // 3: B/3 offer frozen while A/0 arrives
        req_b[3] = 1'b1;
        q.push_back(mk(1, 3, "t3a"));
        q.push_back(mk(0, 0, "t3b"));
        wait_valid("t3a");
        req_a[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk($sformatf("t3_hold%0d_valid", i), 32'(irq_valid), 32'd1);
            chk($sformatf("t3_hold%0d_bus", i),   32'(irq_bus),   32'd1);
            chk($sformatf("t3_hold%0d_chan", i),  32'(irq_chan),  32'd3);
        end
        ack(); cyc(1); eoi_pulse();
        wait_valid("t3b");
        ack(); cyc(1); eoi_pulse();
        req_a = '0; req_b = '0;
        cyc(2);

        // 4: masked A/5 retained, offered once enabled
        chan_en[5] = 1'b0;
        req_a[5]   = 1'b1;
        q.push_back(mk(0, 5, "t4"));
        cyc(6);
        chk("t4_masked_valid", 32'(irq_valid),   32'd0);
        chk("t4_masked_busy",  32'(busy_any[0]), 32'd0);
        chan_en = '1;
        cyc(1); chk("t4_busy", 32'(busy_any[0]), 32'd1);
        wait_valid("t4");
        ack(); cyc(1); eoi_pulse();
        req_a = '0;
        cyc(2);

        // 5: lost flag on C/8, clear, clear wins over same-cycle set
        req_c[8] = 1'b1; cyc(1);
        req_c[8] = 1'b0; cyc(1);
        req_c[8] = 1'b1; cyc(1);
        chk("t5_lost_set", 32'(lost), 32'd4);
        lost_clr = 1'b1; cyc(1); lost_clr = 1'b0;
        chk("t5_lost_clr", 32'(lost), 32'd0);
        req_c[8] = 1'b0; cyc(1);
        req_c[8] = 1'b1; lost_clr = 1'b1; cyc(1); lost_clr = 1'b0;
        chk("t5_clr_wins", 32'(lost), 32'd0);
        cyc(1); chk("t5_clr_stays", 32'(lost), 32'd0);

        // 6: reset during the pending C/8 offer, requests held high afterwards
        wait_valid("t6_pre");
        chk("t6_pre_bus", 32'(irq_bus), 32'd2);
        req_a = '1;
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        chk("t6_valid", 32'(irq_valid), 32'd0);
        chk("t6_busy",  32'(busy_any),  32'd0);
        chk("t6_lost",  32'(lost),      32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (irq_valid) seen = 1'b1;
        end
        chk("t6_no_offer", 32'(seen), 32'd0);
        chk("t6_pend_clr", 32'(busy_any), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
